// File: rtl/apb_slave_mem.sv
// APB completer register file: DEPTH words, byte strobes, programmable
// wait states, decode errors on PSLVERR and a saturating error counter.
//
// Ports:
//   axi_apb_clk, axi_apb_rstn   clock, synchronous active-low reset
//   PADDR, PDATA, PWRITE,       APB request from the bridge
//   PENABLE, PSEL, PSTRB
//   PREADY, PRDATA, PSLVERR     registered APB response
//   err_cnt                     transfers completed with PSLVERR=1 (saturating)
module apb_slave_mem #(
    parameter int WIDTH_AD    = 32,
    parameter int WIDTH_DA    = 32,
    parameter int DEPTH       = 16,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  axi_apb_clk,
    input  logic                  axi_apb_rstn,
    input  logic [WIDTH_AD-1:0]   PADDR,
    input  logic [WIDTH_DA-1:0]   PDATA,
    input  logic                  PWRITE,
    input  logic                  PENABLE,
    input  logic                  PSEL,
    input  logic [WIDTH_DA/8-1:0] PSTRB,
    output logic                  PREADY,
    output logic [WIDTH_DA-1:0]   PRDATA,
    output logic                  PSLVERR,
    output logic [7:0]            err_cnt
);

    localparam int LANES = WIDTH_DA / 8;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [WIDTH_AD-1:0] BASE = WIDTH_AD'(BASE_ADDR);
    localparam logic [WIDTH_AD-1:0] SPAN = WIDTH_AD'(DEPTH * 4);

    // Counter reload: the completing access cycle itself is not a wait
    // cycle, so WAIT_CYCLES low cycles need WAIT_CYCLES-1 decrements.
    localparam logic [3:0] WAIT_LOAD =
        4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state, state_n;
    logic [3:0]            wait_cnt, wait_cnt_n;
    logic [AW-1:0]         lat_idx, lat_idx_n;
    logic                  lat_write, lat_write_n;
    logic                  lat_err, lat_err_n;
    logic [WIDTH_DA-1:0]   lat_data, lat_data_n;
    logic [LANES-1:0]      lat_strb, lat_strb_n;

    logic                  pready_n;
    logic [WIDTH_DA-1:0]   prdata_n;
    logic                  pslverr_n;

    logic [WIDTH_DA-1:0]   mem [DEPTH];

    logic [WIDTH_AD:0]     diff;
    logic [WIDTH_AD-1:0]   off;
    logic                  live_err;
    logic [AW-1:0]         live_idx;
    logic                  setup;
    logic                  start;
    logic                  commit;
    logic [WIDTH_DA-1:0]   fwd_word;

    // The extra top bit of diff is the borrow: set when PADDR < BASE.
    assign diff     = {1'b0, PADDR} - {1'b0, BASE};
    assign off      = diff[WIDTH_AD-1:0];
    assign live_err = diff[WIDTH_AD] | (off >= SPAN)
                    | (PADDR[1:0] != 2'b00);
    assign live_idx = off[AW+1:2];

    assign setup  = PSEL & ~PENABLE;
    assign commit = (state == DONE) & lat_write & ~lat_err;

    // With zero wait states a read set up in DONE samples memory on the
    // same edge that commits the previous write; merge it in here.
    always_comb begin
        fwd_word = mem[live_idx];
        if (commit && (lat_idx == live_idx)) begin
            for (int i = 0; i < LANES; i++) begin
                if (lat_strb[i]) begin
                    fwd_word[8*i +: 8] = lat_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        lat_idx_n   = lat_idx;
        lat_write_n = lat_write;
        lat_err_n   = lat_err;
        lat_data_n  = lat_data;
        lat_strb_n  = lat_strb;
        pready_n    = 1'b0;
        prdata_n    = '0;
        pslverr_n   = 1'b0;
        start       = 1'b0;

        unique case (state)
            IDLE: begin
                start = setup;
            end
            ACCESS: begin
                if (!PSEL || !PENABLE) begin
                    state_n = IDLE;
                end else if (wait_cnt != 4'd0) begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end else begin
                    pready_n  = 1'b1;
                    pslverr_n = lat_err;
                    if (!lat_write && !lat_err) begin
                        prdata_n = mem[lat_idx];
                    end
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                start   = setup;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (start) begin
            lat_idx_n   = live_idx;
            lat_write_n = PWRITE;
            lat_err_n   = live_err;
            lat_data_n  = PDATA;
            lat_strb_n  = PSTRB;
            if (WAIT_CYCLES == 0) begin
                pready_n  = 1'b1;
                pslverr_n = live_err;
                if (!PWRITE && !live_err) begin
                    prdata_n = fwd_word;
                end
                state_n = DONE;
            end else begin
                wait_cnt_n = WAIT_LOAD;
                state_n    = ACCESS;
            end
        end
    end

    always_ff @(posedge axi_apb_clk) begin
        if (!axi_apb_rstn) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_data  <= '0;
            lat_strb  <= '0;
            PREADY    <= 1'b0;
            PRDATA    <= '0;
            PSLVERR   <= 1'b0;
            err_cnt   <= 8'd0;
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            lat_idx   <= lat_idx_n;
            lat_write <= lat_write_n;
            lat_err   <= lat_err_n;
            lat_data  <= lat_data_n;
            lat_strb  <= lat_strb_n;
            PREADY    <= pready_n;
            PRDATA    <= prdata_n;
            PSLVERR   <= pslverr_n;
            if (commit) begin
                for (int i = 0; i < LANES; i++) begin
                    if (lat_strb[i]) begin
                        mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
                    end
                end
            end
            // PSLVERR is only ever high during the DONE cycle.
            if (PSLVERR && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
